// File: rtl/uart_tx_serializer_if.sv
// Read-side handshake between the byte-wide TX FIFO and the UART serializer.
// The serializer is the master: it issues the pop strobe and consumes the head byte.
interface uart_tx_serializer_if;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_pop;

    modport master (output fifo_pop, input fifo_empty, input fifo_rdata);
    modport slave  (input fifo_pop, output fifo_empty, output fifo_rdata);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte per frame from the TX FIFO and sends
// start, 8 data bits LSB first, optional even parity and 1 or 2 stop bits.
module uart_tx_serializer #(
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_en,
    input  logic [15:0]                 clk_divider,
    uart_tx_serializer_if.master        fifo_if,
    output logic                        sout,
    output logic                        busy
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_div_cnt;
    logic [15:0] w_div_cnt_next;
    logic [15:0] r_period;
    logic [15:0] w_period_next;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_parity;
    logic        w_parity_next;
    logic        r_sout;
    logic        w_sout_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        w_launch;
    logic        w_bit_end;
    logic        w_frame_end;
    logic        w_pop;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // Reset also blocks the launch so an aborted frame never leads to a pop.
    assign w_launch    = tx_en & ~fifo_if.fifo_empty & ~rst;
    assign w_bit_end   = (r_div_cnt == (r_period - 16'd1));
    assign w_frame_end = (r_state == S_STOP) & w_bit_end & (r_bit_cnt == STOP_LAST);
    assign w_pop       = w_launch & ((r_state == S_IDLE) | w_frame_end);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= 16'd0;
            r_period  <= 16'd1;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_sout    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_div_cnt <= w_div_cnt_next;
            r_period  <= w_period_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_sout    <= w_sout_next;
            r_busy    <= w_busy_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) w_state_next = S_START;
                else          w_state_next = S_IDLE;
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
                else           w_state_next = S_START;
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == 3'd7))
                    w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                else
                    w_state_next = S_DATA;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
                else           w_state_next = S_PARITY;
            end
            S_STOP: begin
                if (w_frame_end) w_state_next = w_launch ? S_START : S_IDLE;
                else             w_state_next = S_STOP;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit timing counters, shift register and latched frame parameters.
    always_comb begin
        w_div_cnt_next = r_div_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_period_next  = r_period;
        if ((r_state == S_IDLE) || w_bit_end) w_div_cnt_next = 16'd0;
        else                                  w_div_cnt_next = r_div_cnt + 16'd1;
        if (w_state_next != r_state)
            w_bit_cnt_next = 3'd0;
        else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP)))
            w_bit_cnt_next = r_bit_cnt + 3'd1;
        else
            w_bit_cnt_next = r_bit_cnt;
        if (w_pop) begin
            w_shift_next  = fifo_if.fifo_rdata;
            w_parity_next = even_parity(fifo_if.fifo_rdata);
            w_period_next = (clk_divider == 16'd0) ? 16'd1 : clk_divider;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_next  = {1'b0, r_shift[7:1]};
        end else begin
            w_shift_next  = r_shift;
        end
    end

    // Outputs: sout/busy are computed from the upcoming state and registered.
    always_comb begin
        w_busy_next = (w_state_next != S_IDLE);
        case (w_state_next)
            S_IDLE:   w_sout_next = 1'b1;
            S_START:  w_sout_next = 1'b0;
            S_DATA:   w_sout_next = w_shift_next[0];
            S_PARITY: w_sout_next = w_parity_next;
            S_STOP:   w_sout_next = 1'b1;
            default:  w_sout_next = 1'b1;
        endcase
    end

    assign fifo_if.fifo_pop = w_pop;
    assign sout             = r_sout;
    assign busy             = r_busy;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: two serializer variants (8N1 and 8E2) share one stimulus
// stream; each has its own FIFO read pointer and a cycle-level line model.
module tb_uart_tx_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en = 1'b0;
    logic [15:0] clk_divider = 16'd4;

    int          n_checks = 0;
    int          n_errors = 0;
    int          timeouts = 0;
    bit          final_chk = 1'b0;
    bit          final_done = 1'b0;

    logic [7:0]  mem [256];
    int          wr_cnt = 0;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s inst%0d actual=%0d expected=%0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int PE = g;
        localparam int SB = g + 1;

        uart_tx_serializer_if f ();
        logic       sout;
        logic       busy;
        int         rd_idx = 0;
        int         n_pop = 0;
        bit         wave [$];
        bit         rst_prev = 1'b0;
        bit         exp_pop;
        bit         exp_sout;
        bit         exp_busy;
        int         per;
        logic [7:0] b;

        uart_tx_serializer #(.PARITY_EN(PE), .STOP_BITS(SB)) dut (
            .clk        (clk),
            .rst        (rst),
            .tx_en      (tx_en),
            .clk_divider(clk_divider),
            .fifo_if    (f),
            .sout       (sout),
            .busy       (busy)
        );

        assign f.fifo_empty = (rd_idx >= wr_cnt);
        assign f.fifo_rdata = mem[rd_idx[7:0]];

        always @(posedge clk) begin
            if (f.fifo_pop && (rd_idx < wr_cnt)) rd_idx <= rd_idx + 1;
        end

        task automatic emit(input bit v, input int p);
            for (int k = 0; k < p; k++) wave.push_back(v);
        endtask

        // Line model: the expected sout level of every future cycle sits in wave.
        always @(negedge clk) begin
            if (rst_prev) wave.delete();
            exp_pop  = !rst && tx_en && (rd_idx < wr_cnt) && (wave.size() <= 1);
            exp_sout = (wave.size() > 0) ? wave[0] : 1'b1;
            exp_busy = (wave.size() > 0);
            check("sout", g, int'(sout), int'(exp_sout));
            check("busy", g, int'(busy), int'(exp_busy));
            check("fifo_pop", g, int'(f.fifo_pop), int'(exp_pop));
            if (wave.size() > 0) void'(wave.pop_front());
            if (f.fifo_pop && (n_pop < exp_q.size())) begin
                b   = exp_q[n_pop];
                n_pop++;
                per = (clk_divider == 16'd0) ? 1 : int'(clk_divider);
                emit(1'b0, per);
                for (int i = 0; i < 8; i++) emit(b[i], per);
                if (PE != 0) emit(^b, per);
                emit(1'b1, per * SB);
            end
            rst_prev = rst;
        end
    end

    // End-of-run accounting: every queued byte sent by both variants, no hangs.
    always @(negedge clk) begin
        if (final_chk && !final_done) begin
            check("timeouts", 0, timeouts, 0);
            check("pop_count", 0, gi[0].n_pop, exp_q.size());
            check("pop_count", 1, gi[1].n_pop, exp_q.size());
            final_done = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_cnt[7:0]] = v;
        exp_q.push_back(v);
        wr_cnt++;
    endtask

    task automatic wait_done(input bit need_drain, input int limit);
        bit done = 1'b0;
        for (int i = 0; (i < limit) && !done; i++) begin
            @(negedge clk);
            if (!gi[0].busy && !gi[1].busy && (gi[0].wave.size() == 0) && (gi[1].wave.size() == 0)
                && (!need_drain || ((gi[0].rd_idx == wr_cnt) && (gi[1].rd_idx == wr_cnt))))
                done = 1'b1;
        end
        if (!done) timeouts++;
        step(1);
    endtask

    initial begin
        int base;
        bit seen;
        int nb;
        rst = 1'b1; tx_en = 1'b0; clk_divider = 16'd4;
        step(3);
        rst = 1'b0;
        step(2);

        tx_en = 1'b1;
        push(8'h55);
        wait_done(1'b1, 300);

        clk_divider = 16'd2;
        push(8'hA3); push(8'h0F);
        wait_done(1'b1, 300);

        clk_divider = 16'd0;
        push(8'hFF);
        wait_done(1'b1, 100);

        clk_divider = 16'd3;
        push(8'h07);
        wait_done(1'b1, 300);

        // Abort a frame with reset during data bit 3; the next byte must follow intact.
        clk_divider = 16'd2;
        base = gi[0].n_pop;
        push(8'h3C); push(8'h81);
        seen = 1'b0;
        for (int i = 0; (i < 100) && !seen; i++) begin
            @(posedge clk);
            if (gi[0].n_pop > base) seen = 1'b1;
        end
        if (!seen) timeouts++;
        #1;
        step(8);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        wait_done(1'b1, 300);

        // Empty FIFO with tx_en high, then tx_en dropped mid-frame with a byte waiting.
        step(20);
        clk_divider = 16'd5;
        push(8'hC6);
        step(10);
        tx_en = 1'b0;
        clk_divider = 16'd1;
        push(8'h5A);
        wait_done(1'b0, 300);
        step(5);
        tx_en = 1'b1;
        wait_done(1'b1, 300);

        for (int it = 0; it < 40; it++) begin
            clk_divider = 16'($urandom_range(0, 5));
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) push(8'($urandom_range(0, 255)));
            step($urandom_range(0, 30));
            if ($urandom_range(0, 3) == 0) begin
                tx_en = 1'b0;
                step($urandom_range(1, 20));
                tx_en = 1'b1;
            end
        end
        wait_done(1'b1, 20000);

        final_chk = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
